// File: rtl/sync_ram_stream_fifo_if.sv
// Stream ports of the RAM-backed FIFO: producer and consumer ready/valid pairs, flush and fill level.
interface sync_ram_stream_fifo_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) ();
  logic                  Flush_SI;
  logic                  WrValid_SI;
  logic                  WrReady_SO;
  logic [DATA_WIDTH-1:0] WrData_DI;
  logic                  RdValid_SO;
  logic                  RdReady_SI;
  logic [DATA_WIDTH-1:0] RdData_DO;
  logic [ADDR_WIDTH:0]   Count_DO;

  modport slave (
    input  Flush_SI, WrValid_SI, WrData_DI, RdReady_SI,
    output WrReady_SO, RdValid_SO, RdData_DO, Count_DO
  );

  modport master (
    output Flush_SI, WrValid_SI, WrData_DI, RdReady_SI,
    input  WrReady_SO, RdValid_SO, RdData_DO, Count_DO
  );
endinterface

// File: rtl/sync_ram_stream_fifo.sv
// Ready/valid stream FIFO around a 1W/1R registered-read RAM, with a 2-entry prefetch buffer
// that hides the RAM read latency so both sides can stream at one word per cycle.
module sync_ram_stream_fifo #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_DEPTH = 1024,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  sync_ram_stream_fifo_if.slave fifo
);

  localparam int                    IDX_WIDTH = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(DATA_DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = ADDR_WIDTH'(DATA_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic [1:0]            buf_cnt;
  logic [1:0]            load_idx;
  logic [1:0]            slots_used;
  logic                  rd_pend;
  logic                  wr_ready;
  logic                  rd_valid;
  logic                  push;
  logic                  pop;
  logic                  issue;

  // A pop in this cycle frees a buffer slot, which is what keeps full-rate streaming gap-free.
  always_comb begin
    wr_ready   = Rst_RBI && (count < DEPTH_CNT);
    rd_valid   = Rst_RBI && (buf_cnt != 2'd0);
    push       = fifo.WrValid_SI && wr_ready && !fifo.Flush_SI;
    pop        = rd_valid && fifo.RdReady_SI && !fifo.Flush_SI;
    load_idx   = buf_cnt - {1'b0, pop};
    slots_used = load_idx + {1'b0, rd_pend};
    issue      = Rst_RBI && !fifo.Flush_SI && (ram_cnt != '0) && (slots_used < 2'd2);
  end

  always_ff @(posedge Clk_CI) begin
    if (push) mem[wr_ptr[IDX_WIDTH-1:0]] <= fifo.WrData_DI;
    if (issue) ram_rdata <= mem[rd_ptr[IDX_WIDTH-1:0]];
  end

  // ram_cnt only sees a word after its write edge, so a read never hits the address being written.
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI || fifo.Flush_SI) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ram_cnt  <= '0;
      buf_cnt  <= '0;
      rd_pend  <= 1'b0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
      if (issue) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
      case ({push, issue})
        2'b10:   ram_cnt <= ram_cnt + CNT_ONE;
        2'b01:   ram_cnt <= ram_cnt - CNT_ONE;
        default: ;
      endcase
      rd_pend <= issue;
      buf_cnt <= slots_used;
      if (pop && (buf_cnt == 2'd2)) buf_q[0] <= buf_q[1];
      if (rd_pend) buf_q[load_idx[0]] <= ram_rdata;
    end
  end

  assign fifo.WrReady_SO = wr_ready;
  assign fifo.RdValid_SO = rd_valid;
  assign fifo.Count_DO   = Rst_RBI ? count : '0;
  assign fifo.RdData_DO  = Rst_RBI ? buf_q[0] : '0;

`ifndef SYNTHESIS
  if ((DATA_DEPTH < 2) || ((2 ** ADDR_WIDTH) < DATA_DEPTH)) begin : g_bad_params
    $error("sync_ram_stream_fifo: DATA_DEPTH must be in 2..2**ADDR_WIDTH");
  end

  a_no_push_full: assert property (@(posedge Clk_CI) disable iff (!Rst_RBI)
    push |-> (count < DEPTH_CNT));

  a_rd_stable: assert property (@(posedge Clk_CI) disable iff (!Rst_RBI)
    (rd_valid && !fifo.RdReady_SI && !fifo.Flush_SI) |=> $stable(fifo.RdData_DO));
`endif

endmodule

// File: tb/tb_sync_ram_stream_fifo.sv
// Randomized and directed bench for sync_ram_stream_fifo against a queue-based reference model.
module tb_sync_ram_stream_fifo;

  localparam int AW    = 3;
  localparam int DEPTH = 5;
  localparam int DW    = 32;

  typedef struct {
    logic [DW-1:0] d;
    int            e;
  } entry_t;

  logic          Clk_CI  = 1'b0;
  logic          Rst_RBI = 1'b0;
  int            total   = 0;
  int            bad     = 0;
  int            pops    = 0;
  int            edge_n  = -1;
  entry_t        q[$];
  logic [DW-1:0] last_data = '0;
  logic [DW-1:0] expq[$];

  always #5 Clk_CI = ~Clk_CI;

  sync_ram_stream_fifo_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fifo_if ();
  sync_ram_stream_fifo_if #(.ADDR_WIDTH(10), .DATA_WIDTH(DW)) fifo_big_if ();

  sync_ram_stream_fifo #(.ADDR_WIDTH(AW), .DATA_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .Clk_CI  (Clk_CI),
    .Rst_RBI (Rst_RBI),
    .fifo    (fifo_if)
  );

  sync_ram_stream_fifo #(.ADDR_WIDTH(10), .DATA_DEPTH(1024), .DATA_WIDTH(DW)) dut_big (
    .Clk_CI  (Clk_CI),
    .Rst_RBI (Rst_RBI),
    .fifo    (fifo_big_if)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s at t=%0t: got 0x%0h expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic wv, input logic [DW-1:0] wd, input logic rr, input logic fl);
    fifo_if.WrValid_SI = wv;
    fifo_if.WrData_DI  = wd;
    fifo_if.RdReady_SI = rr;
    fifo_if.Flush_SI   = fl;
  endtask

  // Head word becomes visible two edges after the edge that accepted it.
  function automatic bit modelValid();
    return (q.size() > 0) && (q[0].e <= edge_n - 2);
  endfunction

  always @(posedge Clk_CI) begin : model
    bit was_valid;
    bit has_room;
    was_valid = modelValid();
    has_room  = (q.size() < DEPTH);
    if (!Rst_RBI || fifo_if.Flush_SI) begin
      q.delete();
      last_data = '0;
    end else begin
      if (was_valid && fifo_if.RdReady_SI) begin
        void'(q.pop_front());
        pops++;
      end
      if (fifo_if.WrValid_SI && has_room) q.push_back('{d: fifo_if.WrData_DI, e: edge_n + 1});
    end
    edge_n++;
    if (modelValid()) last_data = q[0].d;
    #1;
    checkOutput("rd_valid", 64'(fifo_if.RdValid_SO), 64'(Rst_RBI && modelValid()));
    checkOutput("wr_ready", 64'(fifo_if.WrReady_SO), 64'(Rst_RBI && (q.size() < DEPTH)));
    checkOutput("count", 64'(fifo_if.Count_DO), Rst_RBI ? 64'(q.size()) : 64'd0);
    checkOutput("rd_data", 64'(fifo_if.RdData_DO), Rst_RBI ? 64'(last_data) : 64'd0);
  end

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  task automatic flushFifo();
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    @(negedge Clk_CI);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drainCheck(input string name);
    int got;
    got = 0;
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    for (int c = 0; c < 40 && got < expq.size(); c++) begin
      if (fifo_if.RdValid_SO) begin
        checkOutput(name, 64'(fifo_if.RdData_DO), 64'(expq[got]));
        got++;
      end
      @(negedge Clk_CI);
    end
    checkOutput({name, "_n"}, 64'(got), 64'(expq.size()));
    checkOutput({name, "_empty"}, 64'(fifo_if.RdValid_SO), 64'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic runResetCase(input bit use_flush, input logic [DW-1:0] word);
    string tag;
    tag = use_flush ? "t6f" : "t6r";
    flushFifo();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, word + DW'(i + 1), 1'b0, 1'b0);
      @(negedge Clk_CI);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput({tag, "_count3"}, 64'(fifo_if.Count_DO), 64'd3);
    if (use_flush) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    else Rst_RBI = 1'b0;
    #1;
    if (!use_flush) begin
      checkOutput({tag, "_rst_valid"}, 64'(fifo_if.RdValid_SO), 64'd0);
      checkOutput({tag, "_rst_ready"}, 64'(fifo_if.WrReady_SO), 64'd0);
      checkOutput({tag, "_rst_count"}, 64'(fifo_if.Count_DO), 64'd0);
      checkOutput({tag, "_rst_data"}, 64'(fifo_if.RdData_DO), 64'd0);
    end
    @(negedge Clk_CI);
    Rst_RBI = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    #1;
    checkOutput({tag, "_after_count"}, 64'(fifo_if.Count_DO), 64'd0);
    checkOutput({tag, "_after_valid"}, 64'(fifo_if.RdValid_SO), 64'd0);
    checkOutput({tag, "_after_ready"}, 64'(fifo_if.WrReady_SO), 64'd1);
    checkOutput({tag, "_after_data"}, 64'(fifo_if.RdData_DO), 64'd0);
    applyStimulus(1'b1, word, 1'b1, 1'b0);
    @(negedge Clk_CI);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    for (int c = 0; c < 10 && !fifo_if.RdValid_SO; c++) @(negedge Clk_CI);
    checkOutput({tag, "_first_valid"}, 64'(fifo_if.RdValid_SO), 64'd1);
    checkOutput({tag, "_first_data"}, 64'(fifo_if.RdData_DO), 64'(word));
    @(negedge Clk_CI);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin : stimulus
    int got;
    int gaps;
    int start;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    fifo_big_if.WrValid_SI = 1'b0;
    fifo_big_if.WrData_DI  = '0;
    fifo_big_if.RdReady_SI = 1'b0;
    fifo_big_if.Flush_SI   = 1'b0;
    Rst_RBI = 1'b0;
    repeat (3) @(negedge Clk_CI);
    Rst_RBI = 1'b1;

    $display("[TB] latency on the 1024-deep instance");
    fifo_big_if.WrValid_SI = 1'b1;
    fifo_big_if.WrData_DI  = 32'hA5A5_0001;
    fifo_big_if.RdReady_SI = 1'b1;
    @(negedge Clk_CI);
    fifo_big_if.WrValid_SI = 1'b0;
    checkOutput("t1_valid_c1", 64'(fifo_big_if.RdValid_SO), 64'd0);
    checkOutput("t1_count_c1", 64'(fifo_big_if.Count_DO), 64'd1);
    @(negedge Clk_CI);
    checkOutput("t1_valid_c2m", 64'(fifo_big_if.RdValid_SO), 64'd0);
    @(negedge Clk_CI);
    checkOutput("t1_valid_c2", 64'(fifo_big_if.RdValid_SO), 64'd1);
    checkOutput("t1_data_c2", 64'(fifo_big_if.RdData_DO), 64'hA5A5_0001);
    @(negedge Clk_CI);
    checkOutput("t1_count_end", 64'(fifo_big_if.Count_DO), 64'd0);
    checkOutput("t1_valid_end", 64'(fifo_big_if.RdValid_SO), 64'd0);
    fifo_big_if.RdReady_SI = 1'b0;

    $display("[TB] fill to capacity and drain");
    for (int i = 1; i <= 6; i++) begin
      if (i == 6) checkOutput("t2_full_ready", 64'(fifo_if.WrReady_SO), 64'd0);
      applyStimulus(1'b1, DW'(i), 1'b0, 1'b0);
      @(negedge Clk_CI);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("t2_count5", 64'(fifo_if.Count_DO), 64'd5);
    expq.delete();
    for (int i = 1; i <= 5; i++) expq.push_back(DW'(i));
    drainCheck("t2_order");

    $display("[TB] full-rate streaming with pointer wrap");
    flushFifo();
    got = 0;
    gaps = 0;
    for (int c = 0; c < 40 && got < 23; c++) begin
      if (c >= 3 && !fifo_if.RdValid_SO) gaps++;
      if (fifo_if.RdValid_SO) begin
        checkOutput("t3_data", 64'(fifo_if.RdData_DO), 64'(100 + got));
        got++;
      end
      if (c < 23) applyStimulus(1'b1, DW'(100 + c), 1'b1, 1'b0);
      else applyStimulus(1'b0, '0, 1'b1, 1'b0);
      @(negedge Clk_CI);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("t3_words", 64'(got), 64'd23);
    checkOutput("t3_gaps", 64'(gaps), 64'd0);

    $display("[TB] push and pop around the full boundary");
    flushFifo();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, DW'(32'h40 + i), 1'b0, 1'b0);
      @(negedge Clk_CI);
    end
    checkOutput("t4_count5", 64'(fifo_if.Count_DO), 64'd5);
    checkOutput("t4_ready0", 64'(fifo_if.WrReady_SO), 64'd0);
    applyStimulus(1'b1, 32'h50, 1'b1, 1'b0);
    @(negedge Clk_CI);
    checkOutput("t4_count4", 64'(fifo_if.Count_DO), 64'd4);
    checkOutput("t4_ready1", 64'(fifo_if.WrReady_SO), 64'd1);
    applyStimulus(1'b1, 32'h51, 1'b1, 1'b0);
    @(negedge Clk_CI);
    checkOutput("t4_count_hold", 64'(fifo_if.Count_DO), 64'd4);
    expq.delete();
    expq.push_back(32'h42);
    expq.push_back(32'h43);
    expq.push_back(32'h44);
    expq.push_back(32'h51);
    drainCheck("t4_order");

    $display("[TB] random backpressure with continuous pushes");
    flushFifo();
    start = pops;
    for (int c = 0; c < 40000 && (pops - start) < 10000; c++) begin
      applyStimulus(1'b1, DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      @(negedge Clk_CI);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("t5_words", 64'((pops - start) >= 10000), 64'd1);

    $display("[TB] random traffic with flushes and resets");
    for (int c = 0; c < 3000; c++) begin
      Rst_RBI = ($urandom_range(0, 199) != 0);
      applyStimulus(1'($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 99) == 0));
      @(negedge Clk_CI);
    end
    Rst_RBI = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge Clk_CI);

    $display("[TB] reset and flush with a read in flight");
    runResetCase(1'b0, 32'h0000_0077);
    runResetCase(1'b1, 32'h0000_0088);

    repeat (2) @(negedge Clk_CI);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
